// File: rtl/fmesh_destp_encoder_if.sv
// Header-request / route-result bundle between an endpoint injector and the destp encoder.
// The master drives requests and accepts results; the slave is the encoder.
interface fmesh_destp_encoder_if #(
    parameter int EAw   = 7,
    parameter int PLw   = 3,
    parameter int DISTw = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [EAw-1:0]   src_e_addr;
    logic [EAw-1:0]   dest_e_addr;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       dest_port_coded;
    logic [PLw-1:0]   endp_localp_num;
    logic [DISTw-1:0] distance;
    logic             addr_err;

    modport master (
        output in_valid, src_e_addr, dest_e_addr, out_ready,
        input  in_ready, out_valid, dest_port_coded, endp_localp_num, distance, addr_err
    );

    modport slave (
        input  in_valid, src_e_addr, dest_e_addr, out_ready,
        output in_ready, out_valid, dest_port_coded, endp_localp_num, distance, addr_err
    );
endinterface

// File: rtl/fmesh_destp_encoder.sv
// Source-side fmesh route encoder: computes {x,y,a,b}, local port and hop distance per header,
// buffering results in a 2-entry FIFO and counting invalid destination addresses.
module fmesh_destp_encoder #(
    parameter int    T1         = 4,
    parameter int    T2         = 4,
    parameter int    T3         = 2,
    parameter int    EAw        = 7,
    parameter string ROUTE_TYPE = "DETERMINISTIC",
    parameter int    PLw        = 3,
    parameter int    DISTw      = 4,
    parameter int    CNTw       = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [$clog2(T1)-1:0]                current_x,
    input  logic [$clog2(T2)-1:0]                current_y,
    fmesh_destp_encoder_if.slave                 bus,
    output logic [CNTw-1:0]                      err_cnt,
    input  logic                                 clr_err_cnt
);
    localparam int Xw  = $clog2(T1);
    localparam int Yw  = $clog2(T2);
    localparam int EPw = EAw - Xw - Yw;
    localparam bit DET = (ROUTE_TYPE == "DETERMINISTIC");

    typedef struct packed {
        logic             addr_err;
        logic [3:0]       coded;
        logic [PLw-1:0]   localp;
        logic [DISTw-1:0] distance;
    } entry_t;

    logic [Xw-1:0]  dx, sx, dx_diff;
    logic [Yw-1:0]  dy, sy, dy_diff;
    logic [EPw-1:0] ep;
    logic [EPw-1:0] unused_src_ep;
    logic           addr_ok, hop_a, hop_b, dir_x, dir_y;
    entry_t         new_entry;
    entry_t         mem [2];
    entry_t         head;
    logic           rd_ptr, wr_ptr;
    logic [1:0]     count;
    logic           push, pop;

    assign {ep, dy, dx}            = bus.dest_e_addr;
    assign {unused_src_ep, sy, sx} = bus.src_e_addr;

    // Route decode: deterministic XY routing finishes x before it is allowed to move in y.
    always_comb begin
        addr_ok = (32'(dx) <= T1 - 1) && (32'(dy) <= T2 - 1) && (32'(ep) <= 5 + T3 - 2);
        hop_a   = (dx != current_x);
        hop_b   = (dy != current_y);
        if (DET && hop_a) begin
            hop_b = 1'b0;
        end
        dir_x   = hop_a && (dx > current_x);
        dir_y   = hop_b && (dy < current_y);
        dx_diff = (dx > sx) ? (dx - sx) : (sx - dx);
        dy_diff = (dy > sy) ? (dy - sy) : (sy - dy);

        new_entry          = '0;
        new_entry.addr_err = !addr_ok;
        new_entry.coded    = addr_ok ? {dir_x, dir_y, hop_a, hop_b} : 4'b0000;
        new_entry.localp   = (addr_ok && !hop_a && !hop_b) ? PLw'(ep) : '0;
        new_entry.distance = DISTw'(dx_diff) + DISTw'(dy_diff) + DISTw'(1);
    end

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Storage is cleared on reset too, so the head-driven outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A clear wins over an invalid address accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (clr_err_cnt) begin
            err_cnt <= '0;
        end else if (push && !addr_ok && (err_cnt != {CNTw{1'b1}})) begin
            err_cnt <= err_cnt + CNTw'(1);
        end
    end

    assign head                = mem[rd_ptr];
    assign bus.dest_port_coded = head.coded;
    assign bus.endp_localp_num = head.localp;
    assign bus.distance        = head.distance;
    assign bus.addr_err        = head.addr_err;
endmodule

// File: tb/tb_fmesh_destp_encoder.sv
// Directed bench for fmesh_destp_encoder: one deterministic and one adaptive instance
// share clock, reset and stimulus; router position is fixed at (1,1).
module tb_fmesh_destp_encoder;
    localparam int EAw   = 7;
    localparam int PLw   = 3;
    localparam int DISTw = 4;
    localparam int CNTw  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      cur_x = 2'd1;
    logic [1:0]      cur_y = 2'd1;
    logic            clr_err_cnt;
    logic [CNTw-1:0] det_err_cnt, ada_err_cnt;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    fmesh_destp_encoder_if #(.EAw(EAw), .PLw(PLw), .DISTw(DISTw)) det_if ();
    fmesh_destp_encoder_if #(.EAw(EAw), .PLw(PLw), .DISTw(DISTw)) ada_if ();

    fmesh_destp_encoder #(
        .T1(4), .T2(4), .T3(2), .EAw(EAw), .ROUTE_TYPE("DETERMINISTIC"),
        .PLw(PLw), .DISTw(DISTw), .CNTw(CNTw)
    ) u_det (
        .clk(clk), .reset(reset), .current_x(cur_x), .current_y(cur_y),
        .bus(det_if.slave), .err_cnt(det_err_cnt), .clr_err_cnt(clr_err_cnt)
    );

    fmesh_destp_encoder #(
        .T1(4), .T2(4), .T3(2), .EAw(EAw), .ROUTE_TYPE("ADAPTIVE"),
        .PLw(PLw), .DISTw(DISTw), .CNTw(CNTw)
    ) u_ada (
        .clk(clk), .reset(reset), .current_x(cur_x), .current_y(cur_y),
        .bus(ada_if.slave), .err_cnt(ada_err_cnt), .clr_err_cnt(clr_err_cnt)
    );

    function automatic logic [6:0] mk(input int ep, input int y, input int x);
        return {3'(ep), 2'(y), 2'(x)};
    endfunction

    task automatic applyStimulus(input logic v, input logic [6:0] src, input logic [6:0] dest);
        det_if.in_valid    = v;
        det_if.src_e_addr  = src;
        det_if.dest_e_addr = dest;
        ada_if.in_valid    = v;
        ada_if.src_e_addr  = src;
        ada_if.dest_e_addr = dest;
    endtask

    task automatic setReady(input logic r);
        det_if.out_ready = r;
        ada_if.out_ready = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [6:0] src;
        src = mk(0, 1, 1);

        reset       = 1'b0;
        clr_err_cnt = 1'b0;
        applyStimulus(1'b0, 7'd0, 7'd0);
        setReady(1'b1);
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 32'(det_if.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(det_if.in_ready), 32'd1);
        checkOutput("rst_coded", 32'(det_if.dest_port_coded), 32'd0);
        checkOutput("rst_localp", 32'(det_if.endp_localp_num), 32'd0);
        checkOutput("rst_distance", 32'(det_if.distance), 32'd0);
        checkOutput("rst_addr_err", 32'(det_if.addr_err), 32'd0);
        checkOutput("rst_err_cnt", 32'(det_err_cnt), 32'd0);
        reset = 1'b1;

        // East hop, one cycle latency
        applyStimulus(1'b1, src, mk(0, 1, 3));
        @(negedge clk);
        applyStimulus(1'b0, src, mk(0, 1, 3));
        checkOutput("t1_out_valid", 32'(det_if.out_valid), 32'd1);
        checkOutput("t1_coded", 32'(det_if.dest_port_coded), 32'b1010);
        checkOutput("t1_localp", 32'(det_if.endp_localp_num), 32'd0);
        checkOutput("t1_distance", 32'(det_if.distance), 32'd3);
        checkOutput("t1_addr_err", 32'(det_if.addr_err), 32'd0);

        // North hop, then local delivery
        applyStimulus(1'b1, src, mk(0, 0, 1));
        @(negedge clk);
        checkOutput("t2_north_coded", 32'(det_if.dest_port_coded), 32'b0101);
        checkOutput("t2_north_distance", 32'(det_if.distance), 32'd2);
        applyStimulus(1'b1, src, mk(5, 1, 1));
        @(negedge clk);
        applyStimulus(1'b0, src, mk(5, 1, 1));
        checkOutput("t2_local_coded", 32'(det_if.dest_port_coded), 32'b0000);
        checkOutput("t2_local_localp", 32'(det_if.endp_localp_num), 32'd5);
        checkOutput("t2_local_distance", 32'(det_if.distance), 32'd1);
        @(negedge clk);
        checkOutput("t2_drained", 32'(det_if.out_valid), 32'd0);

        // Diagonal destination: adaptive flags both dims, XY only x
        applyStimulus(1'b1, src, mk(0, 3, 0));
        @(negedge clk);
        applyStimulus(1'b0, src, mk(0, 3, 0));
        checkOutput("t3_ada_coded", 32'(ada_if.dest_port_coded), 32'b0011);
        checkOutput("t3_det_coded", 32'(det_if.dest_port_coded), 32'b0010);
        checkOutput("t3_distance", 32'(det_if.distance), 32'd4);
        @(negedge clk);

        // Invalid endpoint, then saturation over 301 accepts, then clear beating an increment
        applyStimulus(1'b1, src, mk(7, 1, 1));
        @(negedge clk);
        checkOutput("t4_addr_err", 32'(det_if.addr_err), 32'd1);
        checkOutput("t4_coded", 32'(det_if.dest_port_coded), 32'd0);
        checkOutput("t4_localp", 32'(det_if.endp_localp_num), 32'd0);
        checkOutput("t4_err_cnt_1", 32'(det_err_cnt), 32'd1);
        repeat (300) @(negedge clk);
        checkOutput("t4_err_cnt_sat", 32'(det_err_cnt), 32'd255);
        checkOutput("t4_in_ready_stream", 32'(det_if.in_ready), 32'd1);
        clr_err_cnt = 1'b1;
        @(negedge clk);
        clr_err_cnt = 1'b0;
        applyStimulus(1'b0, src, mk(7, 1, 1));
        checkOutput("t4_err_cnt_clr", 32'(det_err_cnt), 32'd0);
        @(negedge clk);
        checkOutput("t4_drained", 32'(det_if.out_valid), 32'd0);
        checkOutput("t4_err_cnt_hold", 32'(det_err_cnt), 32'd0);

        // Back-pressure: two fill the buffer, third is held, then all three drain in order
        setReady(1'b0);
        applyStimulus(1'b1, src, mk(0, 1, 3));
        @(negedge clk);
        checkOutput("t5_in_ready_c1", 32'(det_if.in_ready), 32'd1);
        checkOutput("t5_head_h1", 32'(det_if.dest_port_coded), 32'b1010);
        applyStimulus(1'b1, src, mk(0, 0, 1));
        @(negedge clk);
        checkOutput("t5_in_ready_full", 32'(det_if.in_ready), 32'd0);
        checkOutput("t5_head_h1_stable", 32'(det_if.dest_port_coded), 32'b1010);
        applyStimulus(1'b1, src, mk(0, 3, 0));
        @(negedge clk);
        checkOutput("t5_in_ready_held", 32'(det_if.in_ready), 32'd0);
        checkOutput("t5_head_h1_held", 32'(det_if.dest_port_coded), 32'b1010);
        checkOutput("t5_dist_h1_held", 32'(det_if.distance), 32'd3);
        setReady(1'b1);
        @(negedge clk);
        checkOutput("t5_head_h2", 32'(det_if.dest_port_coded), 32'b0101);
        checkOutput("t5_dist_h2", 32'(det_if.distance), 32'd2);
        checkOutput("t5_in_ready_free", 32'(det_if.in_ready), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, src, mk(0, 3, 0));
        checkOutput("t5_head_h3", 32'(det_if.dest_port_coded), 32'b0010);
        checkOutput("t5_dist_h3", 32'(det_if.distance), 32'd4);
        @(negedge clk);
        checkOutput("t5_no_dup", 32'(det_if.out_valid), 32'd0);

        // Reset while full discards both entries
        setReady(1'b0);
        applyStimulus(1'b1, src, mk(7, 1, 1));
        @(negedge clk);
        applyStimulus(1'b1, src, mk(0, 1, 3));
        @(negedge clk);
        applyStimulus(1'b0, src, mk(0, 1, 3));
        checkOutput("t6_full", 32'(det_if.in_ready), 32'd0);
        checkOutput("t6_err_cnt_pre", 32'(det_err_cnt), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t6_out_valid", 32'(det_if.out_valid), 32'd0);
        checkOutput("t6_in_ready", 32'(det_if.in_ready), 32'd1);
        checkOutput("t6_err_cnt", 32'(det_err_cnt), 32'd0);
        checkOutput("t6_coded", 32'(det_if.dest_port_coded), 32'd0);
        reset = 1'b1;
        setReady(1'b1);
        @(negedge clk);
        checkOutput("t6_not_emitted", 32'(det_if.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
